// File: rtl/fp_denormalizer.sv
// Two-stage denormalizer: converts a normalized FP value (hidden-bit significand
// plus biased exponent) into a fixed-point magnitude aligned to a per-beat
// reference exponent. Stage 1 captures the beat and the exponent difference;
// stage 2 shifts, saturates and forms the sticky bit. Valid/ready on both sides.
module fp_denormalizer #(
   parameter int EXP_WIDTH     = 5,
   parameter int MAN_IN_WIDTH  = 10,
   parameter int MAN_OUT_WIDTH = 15,
   parameter int INT_LEN       = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     sign_in,
   input  logic [EXP_WIDTH-1:0]     exp_in,
   input  logic [MAN_IN_WIDTH-1:0]  man_in,
   input  logic [EXP_WIDTH-1:0]     ref_exp,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     sign_out,
   output logic [MAN_OUT_WIDTH-1:0] man_out,
   output logic                     sticky,
   output logic                     ovf
);

   localparam int SIG_W = MAN_IN_WIDTH + 1;
   localparam int D_W   = EXP_WIDTH + 1;
   localparam int IDX_W = $clog2(SIG_W + 1);
   // Largest left shift that still fits the integer field.
   localparam logic [D_W-1:0] LEFT_MAX  = D_W'(INT_LEN - 1);
   // Right shifts of this size or more push the whole significand out.
   localparam logic [D_W-1:0] RIGHT_ALL = D_W'(SIG_W);

   // Stage 1 state
   logic                     s1_valid_reg;
   logic                     s1_sign_reg;
   logic                     s1_zero_reg;
   logic [SIG_W-1:0]         s1_sig_reg;
   logic [D_W-1:0]           s1_d_reg;

   // Stage 2 (output) state
   logic                     out_valid_reg;
   logic                     sign_out_reg;
   logic [MAN_OUT_WIDTH-1:0] man_out_reg;
   logic                     sticky_reg;
   logic                     ovf_reg;

   // Handshake and datapath intermediates
   logic                     s2_load;
   logic                     in_fire;
   logic [D_W-1:0]           d_next;
   logic                     d_neg;
   logic [D_W-1:0]           d_mag;
   logic [MAN_OUT_WIDTH-1:0] sig_ext;
   logic [SIG_W:0]           lost_or;
   logic [MAN_OUT_WIDTH-1:0] man_next;
   logic                     sticky_next;
   logic                     ovf_next;

   // Stage 2 refills when empty or draining; stage 1 follows it, so the
   // ready path depends only on out_ready and internal state, never on in_valid.
   assign s2_load  = !out_valid_reg || out_ready;
   assign in_ready = !s1_valid_reg || s2_load;
   assign in_fire  = in_valid && in_ready;

   // Signed exponent difference, one bit wider so it never wraps.
   assign d_next = {1'b0, exp_in} - {1'b0, ref_exp};

   // Stage 1: capture the beat, or empty out when stage 2 takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_sign_reg  <= 1'b0;
         s1_zero_reg  <= 1'b0;
         s1_sig_reg   <= '0;
         s1_d_reg     <= '0;
      end else if (in_fire) begin
         s1_valid_reg <= 1'b1;
         s1_sign_reg  <= sign_in;
         s1_zero_reg  <= (exp_in == '0);
         s1_sig_reg   <= {1'b1, man_in};
         s1_d_reg     <= d_next;
      end else if (s2_load) begin
         s1_valid_reg <= 1'b0;
      end
   end

   assign d_neg   = s1_d_reg[D_W-1];
   assign d_mag   = d_neg ? (~s1_d_reg + D_W'(1)) : s1_d_reg;
   assign sig_ext = {{(MAN_OUT_WIDTH-SIG_W){1'b0}}, s1_sig_reg};

   // lost_or[k] is the OR of the k lowest significand bits, i.e. the sticky
   // value for a right shift by k.
   assign lost_or[0] = 1'b0;
   genvar gi;
   generate
      for (gi = 1; gi <= SIG_W; gi++) begin : g_lost
         localparam logic [SIG_W-1:0] LOW_MASK = SIG_W'((1 << gi) - 1);
         assign lost_or[gi] = |(s1_sig_reg & LOW_MASK);
      end
   endgenerate

   // Alignment: zero flush, saturating left shift, or sticky right shift.
   always_comb begin
      man_next    = '0;
      sticky_next = 1'b0;
      ovf_next    = 1'b0;
      if (s1_zero_reg) begin
         man_next = '0;
      end else if (!d_neg) begin
         if (d_mag > LEFT_MAX) begin
            man_next = '1;
            ovf_next = 1'b1;
         end else begin
            man_next = sig_ext << d_mag;
         end
      end else if (d_mag >= RIGHT_ALL) begin
         sticky_next = 1'b1;
      end else begin
         man_next    = sig_ext >> d_mag;
         sticky_next = lost_or[d_mag[IDX_W-1:0]];
      end
   end

   // Stage 2: register results; holds everything while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         sign_out_reg  <= 1'b0;
         man_out_reg   <= '0;
         sticky_reg    <= 1'b0;
         ovf_reg       <= 1'b0;
      end else if (s2_load) begin
         out_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            sign_out_reg <= s1_sign_reg;
            man_out_reg  <= man_next;
            sticky_reg   <= sticky_next;
            ovf_reg      <= ovf_next;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign sign_out  = sign_out_reg;
   assign man_out   = man_out_reg;
   assign sticky    = sticky_reg;
   assign ovf       = ovf_reg;

endmodule

// File: tb/tb_fp_denormalizer.sv
// Bench for fp_denormalizer: directed vector table, backpressure and
// mid-stream reset sequences, and randomized beats against an arithmetic model.
module tb_fp_denormalizer;

   localparam int INT_LEN = 4;

   typedef struct {
      logic        sign;
      logic [4:0]  e;
      logic [9:0]  m;
      logic [4:0]  r;
      logic [14:0] man;
      logic        sticky;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic        sign;
      logic [14:0] man;
      logic        sticky;
      logic        ovf;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        sign_in;
   logic [4:0]  exp_in;
   logic [9:0]  man_in;
   logic [4:0]  ref_exp;
   logic        out_valid;
   logic        out_ready;
   logic        sign_out;
   logic [14:0] man_out;
   logic        sticky;
   logic        ovf;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_in    = 0;
   int   n_out   = 0;
   int   cyc     = 0;
   logic check_lat = 1'b0;
   logic saw_block = 1'b0;
   logic rand_done = 1'b0;
   exp_t cur_exp;
   exp_t q[$];

   logic        prev_stall = 1'b0;
   logic        snap_sign;
   logic [14:0] snap_man;
   logic        snap_sticky;
   logic        snap_ovf;

   fp_denormalizer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sign_in   (sign_in),
      .exp_in    (exp_in),
      .man_in    (man_in),
      .ref_exp   (ref_exp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sign_out  (sign_out),
      .man_out   (man_out),
      .sticky    (sticky),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Value = significand * 2^(exp-ref) in output LSB units; truncate, flag
   // any discarded remainder, saturate past the integer field.
   function automatic exp_t model(input logic s, input int e, input int m, input int r);
      exp_t   x;
      longint sig;
      longint dv;
      int     d;
      x.sign = s; x.man = '0; x.sticky = 1'b0; x.ovf = 1'b0; x.cyc = 0;
      if (e == 0) return x;
      sig = longint'(1024 + m);
      d   = e - r;
      if (d > INT_LEN - 1) begin
         x.man = 15'h7FFF;
         x.ovf = 1'b1;
      end else if (d >= 0) begin
         x.man = 15'(sig * (longint'(1) << d));
      end else begin
         dv       = longint'(1) << (-d);
         x.man    = 15'(sig / dv);
         x.sticky = (sig % dv) != 0;
      end
      return x;
   endfunction

   // Present one beat and hold it until it is accepted.
   task automatic send(input logic s, input logic [4:0] e, input logic [9:0] m,
                       input logic [4:0] r, input exp_t ex);
      int waits = 0;
      sign_in = s; exp_in = e; man_in = m; ref_exp = r;
      cur_exp = ex;
      in_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (in_ready) break;
         waits++;
         if (waits > 200) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles required acceptance", waits);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      out_ready = 1'b1;
      while (q.size() != 0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain_empty", q.size(), 0);
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      exp_t x;
      if (!rst_n) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         check("in_ready", {31'd0, in_ready}, {31'd0, !(q.size() == 2 && !out_ready)});
         if (in_valid && !in_ready && out_valid && !out_ready) saw_block = 1'b1;
         if (prev_stall) begin
            check("stall_valid",  {31'd0, out_valid}, 32'd1);
            check("stall_man",    {17'd0, man_out},   {17'd0, snap_man});
            check("stall_sign",   {31'd0, sign_out},  {31'd0, snap_sign});
            check("stall_sticky", {31'd0, sticky},    {31'd0, snap_sticky});
            check("stall_ovf",    {31'd0, ovf},       {31'd0, snap_ovf});
         end
         if (out_valid && out_ready) begin
            n_out++;
            $display("[TB] out #%0d sign=%0b man=%04h sticky=%0b ovf=%0b", n_out, sign_out, man_out, sticky, ovf);
            if (q.size() == 0) begin
               check("unexpected_output", {31'd0, out_valid}, 32'd0);
            end else begin
               x = q.pop_front();
               check("sign",   {31'd0, sign_out}, {31'd0, x.sign});
               check("man",    {17'd0, man_out},  {17'd0, x.man});
               check("sticky", {31'd0, sticky},   {31'd0, x.sticky});
               check("ovf",    {31'd0, ovf},      {31'd0, x.ovf});
               if (check_lat) check("latency", cyc - x.cyc, 2);
            end
         end
         if (in_valid && in_ready) begin
            x = cur_exp;
            x.cyc = cyc;
            q.push_back(x);
            n_in++;
         end
         prev_stall  = out_valid && !out_ready;
         snap_sign   = sign_out;
         snap_man    = man_out;
         snap_sticky = sticky;
         snap_ovf    = ovf;
      end
   end

   vec_t tv[12];

   initial begin
      exp_t ex;
      int   n0;
      tv[0]  = '{1'b0, 5'd15, 10'h000, 5'd15, 15'h0400, 1'b0, 1'b0};
      tv[1]  = '{1'b1, 5'd18, 10'h200, 5'd15, 15'h3000, 1'b0, 1'b0};
      tv[2]  = '{1'b0, 5'd19, 10'h200, 5'd15, 15'h7FFF, 1'b0, 1'b1};
      tv[3]  = '{1'b0, 5'd13, 10'h003, 5'd15, 15'h0100, 1'b1, 1'b0};
      tv[4]  = '{1'b1, 5'd2,  10'h155, 5'd15, 15'h0000, 1'b1, 1'b0};
      tv[5]  = '{1'b0, 5'd0,  10'h3FF, 5'd15, 15'h0000, 1'b0, 1'b0};
      tv[6]  = '{1'b0, 5'd5,  10'h000, 5'd15, 15'h0001, 1'b0, 1'b0};
      tv[7]  = '{1'b0, 5'd4,  10'h000, 5'd15, 15'h0000, 1'b1, 1'b0};
      tv[8]  = '{1'b0, 5'd17, 10'h3FF, 5'd14, 15'h3FF8, 1'b0, 1'b0};
      tv[9]  = '{1'b1, 5'd31, 10'h000, 5'd0,  15'h7FFF, 1'b0, 1'b1};
      tv[10] = '{1'b0, 5'd0,  10'h000, 5'd31, 15'h0000, 1'b0, 1'b0};
      tv[11] = '{1'b0, 5'd14, 10'h001, 5'd15, 15'h0200, 1'b1, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      sign_in = 1'b0; exp_in = '0; man_in = '0; ref_exp = '0;
      cur_exp = model(1'b0, 0, 0, 0);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_man",       {17'd0, man_out},   32'd0);
      check("rst_sign",      {31'd0, sign_out},  32'd0);
      check("rst_sticky",    {31'd0, sticky},    32'd0);
      check("rst_ovf",       {31'd0, ovf},       32'd0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors, back to back with the consumer always ready.
      check_lat = 1'b1;
      for (int i = 0; i < 12; i++) begin
         ex.sign = tv[i].sign; ex.man = tv[i].man; ex.sticky = tv[i].sticky;
         ex.ovf = tv[i].ovf; ex.cyc = 0;
         send(tv[i].sign, tv[i].e, tv[i].m, tv[i].r, ex);
      end
      drain();
      check_lat = 1'b0;

      // Backpressure: five beats streamed, consumer stalled in cycles 2..6.
      n0 = n_out;
      saw_block = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++)
               send(1'(i), 5'(12 + i), 10'(37 * i + 5), 5'd14, model(1'(i), 12 + i, 37 * i + 5, 14));
         end
         begin
            out_ready = 1'b1;
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check("bp_in_ready_fell", {31'd0, saw_block}, 32'd1);
      check("bp_beat_count", n_out - n0, 5);

      // Reset with two beats in flight.
      out_ready = 1'b1;
      send(1'b1, 5'd15, 10'h2AA, 5'd15, model(1'b1, 15, 'h2AA, 15));
      send(1'b0, 5'd16, 10'h011, 5'd15, model(1'b0, 16, 'h011, 15));
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_man",       {17'd0, man_out},   32'd0);
      check("mid_rst_sign",      {31'd0, sign_out},  32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      n0 = n_out;
      check_lat = 1'b1;
      send(1'b0, 5'd17, 10'h0F0, 5'd16, model(1'b0, 17, 'h0F0, 16));
      drain();
      check_lat = 1'b0;
      check("post_rst_count", n_out - n0, 1);

      // Randomized beats with a randomly stalling consumer.
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               int r, e, m, s;
               r = int'($urandom_range(0, 31));
               e = r + int'($urandom_range(0, 20)) - 14;
               if (e < 1) e = 1;
               if (e > 31) e = 31;
               if ($urandom_range(0, 9) == 0) e = 0;
               m = int'($urandom_range(0, 1023));
               s = int'($urandom_range(0, 1));
               if ($urandom_range(0, 4) == 0) begin
                  @(posedge clk); #1;
               end
               send(1'(s), 5'(e), 10'(m), 5'(r), model(1'(s), e, m, r));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk); #1;
            end
         end
      join
      drain();
      check("total_in_out", n_in - n_out, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_denormalizer.md
Name: fp_denormalizer

Overview:
- Inverse of the normalizer: takes a normalized FP value (exponent + 10-bit fraction with hidden bit) and produces a fixed-point magnitude aligned to a caller-supplied reference exponent.
- Output format: INT_LEN integer bits followed by MAN_OUT_WIDTH-INT_LEN fraction bits.
- Sits on the FMA input path, feeding aligned addends into the wide fixed-point adder.
- Two-stage pipeline with valid/ready backpressure on both sides.

Parameters:
- EXP_WIDTH, 5, exponent width.
- MAN_IN_WIDTH, 10, stored fraction width of the input (hidden bit implicit).
- MAN_OUT_WIDTH, 15, fixed-point output width.
- INT_LEN, 4, integer bits of the output; fraction bits F = MAN_OUT_WIDTH-INT_LEN = 11.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- sign_in  in  1  sign, passed through unchanged.
- exp_in  in  EXP_WIDTH  biased exponent; 0 means zero (flush, no subnormals).
- man_in  in  MAN_IN_WIDTH  fraction bits.
- ref_exp  in  EXP_WIDTH  alignment exponent; sampled with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- sign_out  out  1  registered sign.
- man_out  out  MAN_OUT_WIDTH  aligned magnitude.
- sticky  out  1  OR of all nonzero bits shifted out on the right.
- ovf  out  1  magnitude exceeds the integer range; man_out saturated.

Behaviour:
- Reset (async, rst_n=0): both stage valids clear; out_valid, sign_out, man_out, sticky, ovf = 0.
  - in_ready may be 1 during reset; no beat is accepted until rst_n=1.
  - A beat in flight when reset asserts is dropped.
- Input transfer: in_valid & in_ready at a clk edge. Output transfer: out_valid & out_ready.
- Stage 1 registers:
  - sign.
  - zero flag = (exp_in==0).
  - significand = {1, man_in}, MAN_IN_WIDTH+1 bits.
  - d = exp_in - ref_exp as signed EXP_WIDTH+1 bits.
- Stage 2 computes and registers the outputs:
  - Base placement: hidden bit lands at man_out bit F-1+(MAN_IN_WIDTH+1-F) = bit 10 for the defaults. Significand bits occupy man_out[10:0] when d=0.
  - zero flag set: man_out = 0, sticky = 0, ovf = 0.
  - 0 < d ≤ INT_LEN-1: left shift by d; ovf = 0.
  - d > INT_LEN-1: man_out = all ones, ovf = 1, sticky = 0.
  - d < 0, s = -d: right shift by s.
    - sticky = OR of the s low significand bits lost.
    - s ≥ MAN_IN_WIDTH+1: man_out = 0, sticky = 1.
- Latency: 2 cycles from input transfer to out_valid when out_ready stays high. Throughput: 1 beat/cycle.
- Backpressure:
  - Stage 2 loads when it is empty or out_ready=1.
  - Stage 1 advances when stage 2 loads.
  - in_ready = !s1_valid | stage-1-advances. This is combinational from out_ready; no combinational path from in_valid to in_ready.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
  - No beat is dropped or duplicated.
- Simultaneous input and output transfer in one cycle: both occur; occupancy is unchanged.
- ref_exp ≥ exp_in cases are legal. ref_exp is captured per beat, so changing it between beats is legal.

Test Plan:
- Aligned: exp_in=15, ref_exp=15, man_in=0, out_ready=1 → 2 cycles later man_out=15'h0400, sticky=0, ovf=0.
- Left shift and overflow:
  - exp_in=18, ref_exp=15, man_in=10'h200 → man_out = 15'h3000 (0x600<<3), ovf=0.
  - exp_in=19, same ref → man_out=15'h7FFF, ovf=1.
- Right shift with sticky:
  - exp_in=13, ref_exp=15, man_in=10'h003 → man_out=15'h0100 (0x403>>2), sticky=1.
  - exp_in=2, ref_exp=15 → man_out=0, sticky=1.
- Zero: exp_in=0, man_in=10'h3FF → man_out=0, sticky=0, ovf=0.
- Backpressure:
  - Stream 5 beats with in_valid=1 constantly; hold out_ready=0 for cycles 2–6.
  - Required: in_ready falls after 2 beats are held.
  - Outputs stay stable while stalled.
  - All 5 results emerge in order, none lost or duplicated.
- Reset mid-stream: assert rst_n=0 asynchronously (between edges) with 2 beats in flight → out_valid=0 and man_out=0 immediately. After release, the first new beat emerges 2 cycles after its transfer.
